pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
- Generic inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB); the consumer of the hazard unit's per-stage flush (*_rst) and write-enable (*_irwr) controls.
- Loads the upstream payload, holds it on stall, or inserts a NOP bubble on flush.
- Keeps saturating stall/flush statistics and a sticky watchdog that flags a stage held longer than MAX_HOLD cycles, which catches hazard-unit deadlock.

Parameters:
- DATA_W, 64, payload width in bits (instruction plus decoded fields).
- BUBBLE, 0, payload loaded on flush (all-zero = sll $0,$0,0 NOP).
- CNT_W, 16, width of stall_cnt and flush_cnt.
- MAX_HOLD, 8, consecutive hold cycles that trip watchdog_err; legal range 1..255.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous bubble insert (driven by the hazard unit *_rst)
- wr_en  in  1  1 = load in_data, 0 = hold (driven by the hazard unit *_irwr)
- in_valid  in  1  upstream payload is a real instruction
- in_data  in  DATA_W  upstream payload
- clr_stats  in  1  synchronous clear of counters and watchdog
- out_valid  out  1  registered valid
- out_data  out  DATA_W  registered payload
- stall_cnt  out  CNT_W  cycles spent holding, saturating
- flush_cnt  out  CNT_W  flush cycles, saturating
- hold_run  out  8  current consecutive-hold length, saturating at 255
- watchdog_err  out  1  sticky; hold_run has reached MAX_HOLD

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, out_data=BUBBLE, stall_cnt=0, flush_cnt=0, hold_run=0, watchdog_err=0.
- All outputs are registered. Payload latency is 1 cycle (in_data sampled at edge N appears after edge N).
- Per-edge action, in priority order:
  1. flush=1: out_data<=BUBBLE, out_valid<=0, regardless of wr_en. Flush beats hold, so flush=1 with wr_en=0 still bubbles.
  2. flush=0, wr_en=0 (HOLD): out_data and out_valid unchanged.
  3. flush=0, wr_en=1 (LOAD): out_data<=in_data, out_valid<=in_valid.
- Mode FSM (implicit, derived from the action above): LOAD, HOLD, FLUSH. No other internal state besides counters.
- stall_cnt: +1 on each HOLD cycle. Saturates at 2^CNT_W-1, no wrap.
- flush_cnt: +1 on each FLUSH cycle, counted whether or not out_valid was 1. Saturates at 2^CNT_W-1.
- hold_run:
  - +1 on HOLD, saturating at 255.
  - Returns to 0 on LOAD or FLUSH.
- watchdog_err:
  - Set on the edge where the next hold_run value equals MAX_HOLD.
  - Remains 1 until clr_stats or reset. Further holds or loads do not clear it.
- clr_stats=1:
  - stall_cnt, flush_cnt and watchdog_err go to 0 on that edge.
  - Clear beats any simultaneous increment or set.
  - hold_run and the payload are unaffected; the pipeline keeps moving.
- rst_n asserted mid-hold or mid-flush: every output immediately takes its reset value. First action on the edge after deassertion follows the normal priority.
- X on wr_en or flush while rst_n=0 is ignored.
- in_valid=0 with LOAD: payload is still captured (out_data<=in_data) but out_valid=0. Downstream gates on out_valid.

Decomposition:
- Shared package pipe_pkg:
  - NOP_INSN (32'h0000_0000)
  - default CNT_W
  - enum stage_mode_e {MODE_LOAD, MODE_HOLD, MODE_FLUSH}, also reused by the hazard unit's debug trace
- Sub-module sat_counter (params W; inputs inc, clr; output cnt):
  - clr beats inc; saturates at all-ones.
  - Instantiated for stall_cnt, flush_cnt and hold_run (W=8).
  - hold_run's clear input is driven by LOAD|FLUSH, not by clr_stats.

Test Plan:
- Reset/load: rst_n low, then high; wr_en=1, in_valid=1, in_data=64'hA5 -> after 1 edge out_data=64'hA5, out_valid=1, all counters 0.
- Load-use stall: hold wr_en=0 for 3 edges while in_data changes to 64'h11 -> out_data stays 64'hA5, stall_cnt=3, hold_run=3. Then wr_en=1 -> out_data=64'h11, hold_run=0.
- Branch flush overriding hold: flush=1, wr_en=0 for 1 edge -> out_data=BUBBLE(0), out_valid=0, flush_cnt=1, stall_cnt unchanged, hold_run=0.
- Watchdog: MAX_HOLD=8; wr_en=0 for 8 edges -> watchdog_err rises on the 8th edge. It stays 1 after wr_en=1 and clears only on the clr_stats edge, which also zeroes stall_cnt (=8 before the clear).
- Saturation and clear collision: CNT_W=4, 20 flush cycles -> flush_cnt=15. Assert clr_stats together with flush -> flush_cnt=0 on that edge.
- Async reset mid-hold: pull rst_n low between edges during a hold with out_data=64'h11 -> out_data=0, out_valid=0 and all counters 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers and the hazard unit's debug trace.
package pipe_pkg;

    localparam logic [31:0] NOP_INSN      = 32'h0000_0000;  // sll $0,$0,0
    localparam int          DEFAULT_CNT_W = 16;

    typedef enum logic [1:0] {
        MODE_LOAD  = 2'd0,
        MODE_HOLD  = 2'd1,
        MODE_FLUSH = 2'd2
    } stage_mode_e;

    // Decode the hazard unit's per-stage controls into the action taken this edge.
    function automatic stage_mode_e decode_mode(input logic flush, input logic wr_en);
        if (flush)
            return MODE_FLUSH;
        else if (!wr_en)
            return MODE_HOLD;
        else
            return MODE_LOAD;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Payload bus between two pipeline stages plus the hazard unit's flush/write controls.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 64
);
    logic              flush;
    logic              wr_en;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;

    modport master (
        output flush, wr_en, in_valid, in_data,
        input  out_valid, out_data
    );

    modport slave (
        input  flush, wr_en, in_valid, in_data,
        output out_valid, out_data
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && (cnt != {W{1'b1}}))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: load / hold / bubble, with stall and flush statistics
// and a sticky watchdog for stages held too long.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = 64,
    parameter logic [DATA_W-1:0] BUBBLE   = DATA_W'(NOP_INSN),
    parameter int                CNT_W    = DEFAULT_CNT_W,
    parameter int                MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipe_stage_reg_if.slave      bus,
    input  logic                 clr_stats,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt,
    output logic [7:0]           hold_run,
    output logic                 watchdog_err
);

    localparam logic [7:0] MAX_HOLD_V = 8'(MAX_HOLD);

    stage_mode_e mode;
    logic        is_load;
    logic        is_hold;
    logic        is_flush;
    logic [7:0]  hold_run_next;

    always_comb begin
        mode     = decode_mode(bus.flush, bus.wr_en);
        is_load  = (mode == MODE_LOAD);
        is_hold  = (mode == MODE_HOLD);
        is_flush = (mode == MODE_FLUSH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= BUBBLE;
        end else begin
            case (mode)
                MODE_FLUSH: begin
                    bus.out_valid <= 1'b0;
                    bus.out_data  <= BUBBLE;
                end
                MODE_LOAD: begin
                    bus.out_valid <= bus.in_valid;
                    bus.out_data  <= bus.in_data;
                end
                default: ;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (is_hold),
        .clr   (clr_stats),
        .cnt   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (is_flush),
        .clr   (clr_stats),
        .cnt   (flush_cnt)
    );

    // The run length tracks pipeline motion, so it is reset by LOAD/FLUSH, not by clr_stats.
    sat_counter #(.W(8)) u_hold_run (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (is_hold),
        .clr   (is_load | is_flush),
        .cnt   (hold_run)
    );

    always_comb begin
        hold_run_next = 8'd0;
        if (is_hold)
            hold_run_next = (hold_run == 8'hFF) ? 8'hFF : hold_run + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            watchdog_err <= 1'b0;
        else if (clr_stats)
            watchdog_err <= 1'b0;
        else if (is_hold && (hold_run_next == MAX_HOLD_V))
            watchdog_err <= 1'b1;
    end

endmodule
